// File: rtl/axi_arb_2to1_if.sv
// AXI4 port bundle (AR/R/AW/W/B) shared by both arbiter masters and the slave.
interface axi_arb_2to1_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    // Side that issues transactions.
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready,
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    // Side that serves transactions.
    modport slave (
        input araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_arb_2to1.sv
// Two-master to one-slave AXI arbiter, one transaction in flight, round-robin
// between masters, read-before-write within the granted master.
module axi_arb_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             aclk,
    input  logic             areset_n,
    axi_arb_2to1_if.slave    m0,
    axi_arb_2to1_if.slave    m1,
    axi_arb_2to1_if.master   s,
    output logic             busy,
    output logic             owner
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

    state_t state;
    logic   last_owner;

    logic req0, req1, gnt, gnt_rd;
    assign req0   = m0.arvalid | m0.awvalid;
    assign req1   = m1.arvalid | m1.awvalid;
    // Tie goes to whoever did not finish last; otherwise the lone requester.
    assign gnt    = (req0 & req1) ? ~last_owner : req1;
    assign gnt_rd = gnt ? m1.arvalid : m0.arvalid;

    // Owner-selected address/data fields, sized by the arbiter parameters.
    logic [ADDR_W-1:0] o_araddr, o_awaddr;
    logic [DATA_W-1:0] o_wdata;
    assign o_araddr = owner ? m1.araddr : m0.araddr;
    assign o_awaddr = owner ? m1.awaddr : m0.awaddr;
    assign o_wdata  = owner ? m1.wdata  : m0.wdata;

    // Arbitration FSM; grant, owner and busy are all registered.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    owner <= gnt;
                    busy  <= 1'b1;
                    state <= gnt_rd ? RD_ADDR : WR_ADDR;
                end
                RD_ADDR: if (s.arvalid & s.arready) state <= RD_DATA;
                RD_DATA: if (s.rvalid & s.rready & s.rlast) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_owner <= owner;
                end
                WR_ADDR: if (s.awvalid & s.awready) state <= WR_DATA;
                WR_DATA: if (s.wvalid & s.wready & s.wlast) state <= WR_RESP;
                WR_RESP: if (s.bvalid & s.bready) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_owner <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel routing: only the channel of the current state is connected,
    // and only to the owner; everything else is held at zero.
    always_comb begin
        s.araddr  = '0; s.arlen  = '0; s.arsize = '0; s.arburst = '0; s.arvalid = 1'b0;
        s.rready  = 1'b0;
        s.awaddr  = '0; s.awlen  = '0; s.awsize = '0; s.awburst = '0; s.awvalid = 1'b0;
        s.wdata   = '0; s.wlast  = 1'b0; s.wvalid = 1'b0;
        s.bready  = 1'b0;
        m0.arready = 1'b0; m0.awready = 1'b0; m0.wready = 1'b0;
        m0.rdata   = '0; m0.rresp = '0; m0.rlast = 1'b0; m0.rvalid = 1'b0;
        m0.bresp   = '0; m0.bvalid = 1'b0;
        m1.arready = 1'b0; m1.awready = 1'b0; m1.wready = 1'b0;
        m1.rdata   = '0; m1.rresp = '0; m1.rlast = 1'b0; m1.rvalid = 1'b0;
        m1.bresp   = '0; m1.bvalid = 1'b0;
        case (state)
            RD_ADDR: begin
                s.araddr  = o_araddr;
                s.arlen   = owner ? m1.arlen   : m0.arlen;
                s.arsize  = owner ? m1.arsize  : m0.arsize;
                s.arburst = owner ? m1.arburst : m0.arburst;
                s.arvalid = owner ? m1.arvalid : m0.arvalid;
                if (owner) m1.arready = s.arready;
                else       m0.arready = s.arready;
            end
            RD_DATA: begin
                s.rready = owner ? m1.rready : m0.rready;
                if (owner) begin
                    m1.rdata = s.rdata; m1.rresp = s.rresp; m1.rlast = s.rlast; m1.rvalid = s.rvalid;
                end else begin
                    m0.rdata = s.rdata; m0.rresp = s.rresp; m0.rlast = s.rlast; m0.rvalid = s.rvalid;
                end
            end
            WR_ADDR: begin
                s.awaddr  = o_awaddr;
                s.awlen   = owner ? m1.awlen   : m0.awlen;
                s.awsize  = owner ? m1.awsize  : m0.awsize;
                s.awburst = owner ? m1.awburst : m0.awburst;
                s.awvalid = owner ? m1.awvalid : m0.awvalid;
                if (owner) m1.awready = s.awready;
                else       m0.awready = s.awready;
            end
            WR_DATA: begin
                s.wdata  = o_wdata;
                s.wlast  = owner ? m1.wlast  : m0.wlast;
                s.wvalid = owner ? m1.wvalid : m0.wvalid;
                if (owner) m1.wready = s.wready;
                else       m0.wready = s.wready;
            end
            WR_RESP: begin
                s.bready = owner ? m1.bready : m0.bready;
                if (owner) begin
                    m1.bresp = s.bresp; m1.bvalid = s.bvalid;
                end else begin
                    m0.bresp = s.bresp; m0.bvalid = s.bvalid;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_arb_2to1.sv
// Directed bench for axi_arb_2to1: the bench plays both masters and the slave.
module tb_axi_arb_2to1;
    logic aclk = 1'b0;
    logic areset_n;
    logic busy, owner;
    int   checks = 0;
    int   failures = 0;

    axi_arb_2to1_if m0 ();
    axi_arb_2to1_if m1 ();
    axi_arb_2to1_if s ();

    axi_arb_2to1 dut (
        .aclk(aclk), .areset_n(areset_n),
        .m0(m0), .m1(m1), .s(s),
        .busy(busy), .owner(owner)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Entered in RD_ADDR at a falling edge; leaves at the falling edge after the last beat.
    task automatic rd_xfer(input int m, input int beats);
        s.arready = 1'b1;
        #1;
        chk("arready_route", m ? m1.arready : m0.arready, 1);
        chk("arready_other", m ? m0.arready : m1.arready, 0);
        tick();
        s.arready = 1'b0;
        if (m) begin m1.arvalid = 1'b0; m1.rready = 1'b1; end
        else   begin m0.arvalid = 1'b0; m0.rready = 1'b1; end
        for (int i = 0; i < beats; i++) begin
            s.rvalid = 1'b1;
            s.rdata  = 32'hA000 + 32'(i) + 32'(m * 16);
            s.rlast  = (i == beats - 1);
            #1;
            chk("rdata", m ? m1.rdata : m0.rdata, 32'hA000 + i + m * 16);
            chk("rlast", m ? m1.rlast : m0.rlast, (i == beats - 1));
            chk("rvalid_other", m ? m0.rvalid : m1.rvalid, 0);
            chk("rdata_other", m ? m0.rdata : m1.rdata, 0);
            chk("s_rready", s.rready, 1);
            tick();
        end
        s.rvalid = 1'b0; s.rlast = 1'b0; s.rdata = '0;
        m0.rready = 1'b0; m1.rready = 1'b0;
    endtask

    // Entered in WR_ADDR; B response is held off for 'stall' cycles by the master.
    task automatic wr_xfer(input int m, input int beats, input int stall);
        s.awready = 1'b1;
        #1;
        chk("awready_route", m ? m1.awready : m0.awready, 1);
        chk("awready_other", m ? m0.awready : m1.awready, 0);
        tick();
        s.awready = 1'b0;
        s.wready  = 1'b1;
        if (m) begin m1.awvalid = 1'b0; m1.wvalid = 1'b1; end
        else   begin m0.awvalid = 1'b0; m0.wvalid = 1'b1; end
        for (int i = 0; i < beats; i++) begin
            if (m) begin m1.wdata = 32'hD100 + 32'(i); m1.wlast = (i == beats - 1); end
            else   begin m0.wdata = 32'hD000 + 32'(i); m0.wlast = (i == beats - 1); end
            #1;
            chk("s_wdata", s.wdata, (m ? 32'hD100 : 32'hD000) + i);
            chk("s_wlast", s.wlast, (i == beats - 1));
            chk("wready_route", m ? m1.wready : m0.wready, 1);
            tick();
        end
        m0.wvalid = 1'b0; m0.wlast = 1'b0; m1.wvalid = 1'b0; m1.wlast = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b1; s.bresp = 2'b01;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_s_bready", s.bready, 0);
            chk("stall_bvalid", m ? m1.bvalid : m0.bvalid, 1);
            chk("stall_owner", owner, m);
            chk("stall_busy", busy, 1);
            tick();
        end
        if (m) m1.bready = 1'b1; else m0.bready = 1'b1;
        #1;
        chk("s_bready", s.bready, 1);
        chk("bresp", m ? m1.bresp : m0.bresp, 2'b01);
        tick();
        s.bvalid = 1'b0; s.bresp = '0;
        m0.bready = 1'b0; m1.bready = 1'b0;
    endtask

    initial begin
        areset_n = 1'b0;
        {m0.araddr, m0.arlen, m0.arsize, m0.arburst, m0.arvalid, m0.rready} = '0;
        {m0.awaddr, m0.awlen, m0.awsize, m0.awburst, m0.awvalid} = '0;
        {m0.wdata, m0.wlast, m0.wvalid, m0.bready} = '0;
        {m1.araddr, m1.arlen, m1.arsize, m1.arburst, m1.arvalid, m1.rready} = '0;
        {m1.awaddr, m1.awlen, m1.awsize, m1.awburst, m1.awvalid} = '0;
        {m1.wdata, m1.wlast, m1.wvalid, m1.bready} = '0;
        {s.arready, s.rdata, s.rresp, s.rlast, s.rvalid} = '0;
        {s.awready, s.wready, s.bresp, s.bvalid} = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_s_arvalid", s.arvalid, 0);
        chk("rst_m0_rvalid", m0.rvalid, 0);
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;

        // m0 read of 4 beats from 0x4
        m0.araddr = 32'h4; m0.arlen = 8'd3; m0.arsize = 3'd2; m0.arburst = 2'b01; m0.arvalid = 1'b1;
        #1;
        chk("grant_registered", s.arvalid, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("s_araddr", s.araddr, 32'h4);
        chk("s_arlen", s.arlen, 3);
        chk("s_arvalid", s.arvalid, 1);
        chk("busy_rd", busy, 1);
        chk("owner_rd", owner, 0);
        rd_xfer(0, 4);
        chk("done_busy", busy, 0);

        // Simultaneous reads right after reset: m0 first, then m1
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        m0.araddr = 32'h100; m0.arlen = 8'd0; m0.arvalid = 1'b1;
        m1.araddr = 32'h200; m1.arlen = 8'd1; m1.arvalid = 1'b1;
        tick();
        chk("tie_owner0", owner, 0);
        chk("tie_addr0", s.araddr, 32'h100);
        rd_xfer(0, 1);
        chk("gap_busy", busy, 0);
        tick();
        chk("rr_busy", busy, 1);
        chk("rr_owner1", owner, 1);
        chk("rr_addr1", s.araddr, 32'h200);
        rd_xfer(1, 2);

        // m1 read+write together: read first, then m0 write, then m1 write
        m1.araddr = 32'h300; m1.arvalid = 1'b1;
        m1.awaddr = 32'h380; m1.awlen = 8'd0; m1.awvalid = 1'b1;
        tick();
        chk("rw_owner1", owner, 1);
        chk("rw_read_first", s.arvalid, 1);
        chk("rw_no_aw", s.awvalid, 0);
        m0.awaddr = 32'h400; m0.awlen = 8'd1; m0.awvalid = 1'b1;
        rd_xfer(1, 1);
        tick();
        chk("wr_owner0", owner, 0);
        chk("wr_s_awaddr0", s.awaddr, 32'h400);
        chk("wr_s_awlen0", s.awlen, 1);
        chk("wr_no_ar", s.arvalid, 0);
        wr_xfer(0, 2, 5);
        chk("wr_done_busy", busy, 0);
        tick();
        chk("wr_owner1", owner, 1);
        chk("wr_s_awaddr1", s.awaddr, 32'h380);
        wr_xfer(1, 1, 0);

        // m0 read completes (m0 last), then reset lands in beat 2 of 4
        m0.araddr = 32'h500; m0.arlen = 8'd0; m0.arvalid = 1'b1;
        tick();
        rd_xfer(0, 1);
        m0.araddr = 32'h600; m0.arlen = 8'd3; m0.arvalid = 1'b1;
        tick();
        s.arready = 1'b1;
        tick();
        s.arready = 1'b0; m0.arvalid = 1'b0; m0.rready = 1'b1;
        s.rvalid = 1'b1; s.rdata = 32'hB000;
        tick();
        s.rdata = 32'hB001;
        #1;
        chk("beat2_rdata", m0.rdata, 32'hB001);
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_m0_rvalid", m0.rvalid, 0);
        chk("arst_m0_rdata", m0.rdata, 0);
        chk("arst_s_rready", s.rready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        tick();
        areset_n = 1'b1;
        s.rvalid = 1'b0; s.rdata = '0; m0.rready = 1'b0;
        m0.araddr = 32'h700; m0.arvalid = 1'b1;
        m1.araddr = 32'h800; m1.arvalid = 1'b1;
        tick();
        chk("post_rst_owner", owner, 0);
        chk("post_rst_addr", s.araddr, 32'h700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
